// File: rtl/cmda_bus_ctrl.sv
// Purpose: DDR3 command/address output bus controller in the clk_div domain; command pipeline, shared tristate, per-lane delay shadows.
// Latency: cmd_in to dout/tout is PIPE_DEPTH+1 cycles; a delay apply keeps dly_busy high for WIDTH+1 cycles.
// Backpressure: none on the command path; delay writes and apply requests are dropped while dly_busy is high.
//
// Ports:
//   clk_div            half-rate clock, the only clock
//   rst                asynchronous reset, active high
//   cmd_in/cmd_valid   command word (lane i in bits [2i+1:2i], bit 2i first) and its valid
//   dout               per-lane din pair to the output cells; NOP_PATTERN when no command
//   tout               shared tristate control, 1 = float after IDLE_CYCLES idle cycles
//   dly_addr/dly_data  lane index and delay value (3 LSB = fine delay) for a shadow write
//   dly_we             shadow write strobe
//   dly_apply          push dirty shadows to the lanes
//   dly_busy           apply sequence in progress
//   lane_dly           delay value presented to all lanes
//   lane_set           one-hot per-lane set_delay strobe
//   lane_ld            broadcast ld_delay strobe
module cmda_bus_ctrl #(
   parameter int               WIDTH       = 16,
   parameter int               DLY_AW      = 5,
   parameter int               PIPE_DEPTH  = 1,
   parameter int               IDLE_CYCLES = 8,
   parameter logic [7:0]       DLY_INIT    = 8'h00,
   parameter logic [2*WIDTH-1:0] NOP_PATTERN = {(2*WIDTH){1'b1}}
) (
   input  logic                 clk_div,
   input  logic                 rst,
   input  logic [2*WIDTH-1:0]   cmd_in,
   input  logic                 cmd_valid,
   output logic [2*WIDTH-1:0]   dout,
   output logic                 tout,
   input  logic [DLY_AW-1:0]    dly_addr,
   input  logic [7:0]           dly_data,
   input  logic                 dly_we,
   input  logic                 dly_apply,
   output logic                 dly_busy,
   output logic [7:0]           lane_dly,
   output logic [WIDTH-1:0]     lane_set,
   output logic                 lane_ld
);

   typedef logic [2*WIDTH-1:0] word_t;

   // ------------------------------------------------------------------
   // Command path
   // ------------------------------------------------------------------

   // Word and valid as they enter the output register stage.
   word_t out_cmd;
   logic  out_vld;

   generate
      if (PIPE_DEPTH == 0) begin : g_nopipe
         assign out_cmd = cmd_in;
         assign out_vld = cmd_valid;
      end else begin : g_pipe
         word_t                 pipe_cmd [PIPE_DEPTH];
         logic [PIPE_DEPTH-1:0] pipe_vld;

         always_ff @(posedge clk_div or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < PIPE_DEPTH; k++) begin
                  pipe_cmd[k] <= '0;
               end
               pipe_vld <= '0;
            end else begin
               pipe_cmd[0] <= cmd_in;
               pipe_vld[0] <= cmd_valid;
               for (int k = 1; k < PIPE_DEPTH; k++) begin
                  pipe_cmd[k] <= pipe_cmd[k-1];
                  pipe_vld[k] <= pipe_vld[k-1];
               end
            end
         end

         assign out_cmd = pipe_cmd[PIPE_DEPTH-1];
         assign out_vld = pipe_vld[PIPE_DEPTH-1];
      end
   endgenerate

   localparam logic [7:0] IDLE_MAX = 8'(IDLE_CYCLES);

   logic [7:0] idle_cnt;
   logic [7:0] idle_cnt_nxt;

   // The counter value that will sit beside the next dout decides tout,
   // so the first word after a float un-floats the bus in its own cycle.
   always_comb begin
      if (out_vld) begin
         idle_cnt_nxt = '0;
      end else if (idle_cnt == IDLE_MAX) begin
         idle_cnt_nxt = idle_cnt;
      end else begin
         idle_cnt_nxt = idle_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         dout     <= NOP_PATTERN;
         tout     <= 1'b1;
         idle_cnt <= IDLE_MAX;
      end else begin
         dout     <= out_vld ? out_cmd : NOP_PATTERN;
         tout     <= (idle_cnt_nxt == IDLE_MAX);
         idle_cnt <= idle_cnt_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Delay shadow registers and apply sequencer
   // ------------------------------------------------------------------

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SET  = 2'd1,
      S_LD   = 2'd2
   } state_t;

   localparam logic [DLY_AW-1:0] IDX_LAST = DLY_AW'(WIDTH - 1);

   state_t            state;
   state_t            state_nxt;
   logic [DLY_AW-1:0] idx;
   logic [DLY_AW-1:0] idx_nxt;

   logic [7:0]        shadow [WIDTH];
   logic [WIDTH-1:0]  dirty;
   logic [WIDTH-1:0]  wr_hit;
   logic [WIDTH-1:0]  dirty_eff;

   logic [WIDTH-1:0]  set_nxt;
   logic              ld_nxt;
   logic [7:0]        dly_nxt;
   logic [7:0]        sel_dly;

   assign dly_busy = (state != S_IDLE);

   // Address decode per lane: an address at or above WIDTH matches no lane
   // and is dropped without aliasing.
   always_comb begin
      wr_hit = '0;
      for (int i = 0; i < WIDTH; i++) begin
         wr_hit[i] = dly_we && !dly_busy && (dly_addr == DLY_AW'(i));
      end
   end

   // Dirty view including a write landing this cycle, so a write issued
   // together with dly_apply is part of that apply.
   assign dirty_eff = dirty | wr_hit;

   // State register
   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         S_IDLE: begin
            if (dly_apply && (|dirty_eff)) begin
               state_nxt = S_SET;
               idx_nxt   = '0;
            end
         end
         S_SET: begin
            if (idx == IDX_LAST) begin
               state_nxt = S_LD;
            end else begin
               idx_nxt = idx + DLY_AW'(1);
            end
         end
         S_LD: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Output logic. Strobes are registered, so they are decoded from the
   // next state/index: lane_set[idx] is visible in the cycle the FSM sits
   // in SET with that idx, and lane_ld in the LD cycle.
   always_comb begin
      set_nxt = '0;
      sel_dly = '0;
      ld_nxt  = (state_nxt == S_LD);
      for (int i = 0; i < WIDTH; i++) begin
         if (idx_nxt == DLY_AW'(i)) begin
            sel_dly    = wr_hit[i] ? dly_data : shadow[i];
            set_nxt[i] = (state_nxt == S_SET) && dirty_eff[i];
         end
      end
      // lane_dly holds its last value between set strobes.
      dly_nxt = (|set_nxt) ? sel_dly : lane_dly;
   end

   // Shadow storage; a lane is cleaned in the same edge its set strobe is launched.
   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) begin
            shadow[i] <= DLY_INIT;
         end
         dirty <= '1;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (wr_hit[i]) begin
               shadow[i] <= dly_data;
            end
         end
         dirty <= dirty_eff & ~set_nxt;
      end
   end

   // Registered strobe outputs
   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         lane_set <= '0;
         lane_ld  <= 1'b0;
         lane_dly <= '0;
      end else begin
         lane_set <= set_nxt;
         lane_ld  <= ld_nxt;
         lane_dly <= dly_nxt;
      end
   end

endmodule

// File: tb/tb_cmda_bus_ctrl.sv
// Bench for cmda_bus_ctrl with WIDTH=16, PIPE_DEPTH=1, IDLE_CYCLES=8, DLY_INIT=0.
// Command path checked from a table of per-cycle vectors; delay apply sequences by hand.
// No ports.
module tb_cmda_bus_ctrl;

   localparam int WIDTH = 16;

   logic          clk_div = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   cmd_in = '0;
   logic          cmd_valid = 1'b0;
   logic [31:0]   dout;
   logic          tout;
   logic [4:0]    dly_addr = '0;
   logic [7:0]    dly_data = '0;
   logic          dly_we = 1'b0;
   logic          dly_apply = 1'b0;
   logic          dly_busy;
   logic [7:0]    lane_dly;
   logic [15:0]   lane_set;
   logic          lane_ld;

   initial forever #5 clk_div = ~clk_div;

   cmda_bus_ctrl #(
      .WIDTH(16),
      .DLY_AW(5),
      .PIPE_DEPTH(1),
      .IDLE_CYCLES(8),
      .DLY_INIT(8'h00),
      .NOP_PATTERN(32'hFFFF_FFFF)
   ) dut (
      .clk_div(clk_div),
      .rst(rst),
      .cmd_in(cmd_in),
      .cmd_valid(cmd_valid),
      .dout(dout),
      .tout(tout),
      .dly_addr(dly_addr),
      .dly_data(dly_data),
      .dly_we(dly_we),
      .dly_apply(dly_apply),
      .dly_busy(dly_busy),
      .lane_dly(lane_dly),
      .lane_set(lane_set),
      .lane_ld(lane_ld)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One record per cycle: inputs applied in that cycle, outputs expected in that cycle.
   typedef struct packed {
      logic        vld;
      logic [31:0] cmd;
      logic [31:0] exp_dout;
      logic        exp_tout;
   } vec_t;

   vec_t vt [19];

   // Observations of one apply sequence
   logic [15:0] obs_mask;
   logic [7:0]  obs_dly [16];
   int          obs_off [16];
   int          busy_cnt;
   int          ld_cnt;
   int          ld_off;
   int          bad_cnt;
   logic [15:0] pre_rst_set;

   task automatic write_dly(input logic [4:0] a, input logic [7:0] d);
      dly_we   = 1'b1;
      dly_addr = a;
      dly_data = d;
      @(negedge clk_div);
      dly_we   = 1'b0;
   endtask

   // Pulse dly_apply (optionally with a same-cycle write), then watch 40 cycles.
   // we_at / rst_at are busy-cycle offsets for a write or reset mid-sequence (-1 = none).
   task automatic run_apply(input logic same_we, input logic [4:0] same_addr, input logic [7:0] same_data,
                            input int we_at, input logic [4:0] we_addr, input logic [7:0] we_data,
                            input int rst_at);
      obs_mask    = '0;
      busy_cnt    = 0;
      ld_cnt      = 0;
      ld_off      = -1;
      bad_cnt     = 0;
      pre_rst_set = '0;
      for (int k = 0; k < 16; k++) begin
         obs_dly[k] = 8'h00;
         obs_off[k] = -1;
      end
      dly_apply = 1'b1;
      dly_we    = same_we;
      dly_addr  = same_addr;
      dly_data  = same_data;
      @(negedge clk_div);
      dly_apply = 1'b0;
      dly_we    = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (dly_busy) begin
            for (int k = 0; k < 16; k++) begin
               if (lane_set[k]) begin
                  obs_mask[k] = 1'b1;
                  obs_dly[k]  = lane_dly;
                  obs_off[k]  = busy_cnt;
               end
            end
            if ((lane_set & (lane_set - 16'd1)) != 16'd0) bad_cnt++;
            if (lane_ld) begin
               ld_cnt++;
               ld_off = busy_cnt;
               if (lane_set != 16'd0) bad_cnt++;
            end
            if (busy_cnt == we_at) begin
               dly_we   = 1'b1;
               dly_addr = we_addr;
               dly_data = we_data;
            end
            if (busy_cnt == rst_at) begin
               pre_rst_set = lane_set;
               #2 rst = 1'b1;
               #1;
               check("rst_async_set", 32'(lane_set), 32'h0);
               check("rst_async_ld", 32'(lane_ld), 32'h0);
               check("rst_async_busy", 32'(dly_busy), 32'h0);
            end
            busy_cnt++;
         end else if (lane_set != 16'd0 || lane_ld) begin
            bad_cnt++;
         end
         @(negedge clk_div);
         dly_we = 1'b0;
         rst    = 1'b0;
      end
   endtask

   task automatic expect_apply(input string tag, input logic [15:0] exp_mask, input int exp_busy, input int exp_ld);
      int misorder = 0;
      check({tag, "_mask"}, 32'(obs_mask), 32'(exp_mask));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
      check({tag, "_ld_count"}, 32'(ld_cnt), 32'(exp_ld));
      if (exp_ld > 0) check({tag, "_ld_offset"}, 32'(ld_off), 32'(WIDTH));
      for (int k = 0; k < 16; k++) begin
         if (obs_mask[k] && obs_off[k] != k) misorder++;
      end
      check({tag, "_set_order"}, 32'(misorder), 32'h0);
      check({tag, "_strobe_rules"}, 32'(bad_cnt), 32'h0);
   endtask

   logic [31:0] hist [22];

   initial begin
      // Command-path vectors: cmd at row 1 appears at row 3, bus floats again at row 11.
      vt[0]  = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
      vt[1]  = '{1'b1, 32'h0000_A5A5, 32'hFFFF_FFFF, 1'b1};
      vt[2]  = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
      vt[3]  = '{1'b0, 32'h0000_0000, 32'h0000_A5A5, 1'b0};
      vt[4]  = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
      vt[5]  = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
      vt[6]  = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
      vt[7]  = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
      vt[8]  = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
      vt[9]  = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
      vt[10] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
      vt[11] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
      vt[12] = '{1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
      vt[13] = '{1'b1, 32'h9ABC_DEF0, 32'hFFFF_FFFF, 1'b1};
      vt[14] = '{1'b0, 32'h0000_0000, 32'h1234_5678, 1'b0};
      vt[15] = '{1'b1, 32'h0F0F_0F0F, 32'h9ABC_DEF0, 1'b0};
      vt[16] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
      vt[17] = '{1'b0, 32'h0000_0000, 32'h0F0F_0F0F, 1'b0};
      vt[18] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};

      // Reset state
      @(negedge clk_div);
      check("reset_dout", dout, 32'hFFFF_FFFF);
      check("reset_tout", 32'(tout), 32'h1);
      check("reset_busy", 32'(dly_busy), 32'h0);
      check("reset_lane_set", 32'(lane_set), 32'h0);
      check("reset_lane_ld", 32'(lane_ld), 32'h0);
      check("reset_lane_dly", 32'(lane_dly), 32'h0);
      @(negedge clk_div);
      rst = 1'b0;
      @(negedge clk_div);

      // Table-driven command path
      for (int t = 0; t < 19; t++) begin
         check($sformatf("vec%0d_dout", t), dout, vt[t].exp_dout);
         check($sformatf("vec%0d_tout", t), 32'(tout), 32'(vt[t].exp_tout));
         cmd_valid = vt[t].vld;
         cmd_in    = vt[t].cmd;
         @(negedge clk_div);
      end
      check("no_strobe_before_apply", 32'({lane_set, lane_ld}), 32'h0);

      // Back-to-back commands for 20 cycles: no NOP gaps, no float
      for (int i = 0; i < 22; i++) begin
         if (i >= 2) begin
            check($sformatf("b2b%0d_dout", i), dout, hist[i-2]);
            check($sformatf("b2b%0d_tout", i), 32'(tout), 32'h0);
         end
         if (i < 20) begin
            hist[i]   = {16'(i), 16'hC3C3 ^ 16'(i * 7)};
            cmd_valid = 1'b1;
            cmd_in    = hist[i];
         end else begin
            cmd_valid = 1'b0;
            cmd_in    = '0;
         end
         @(negedge clk_div);
      end

      // First apply after reset loads every lane with DLY_INIT
      run_apply(1'b0, 5'd0, 8'h00, -1, 5'd0, 8'h00, -1);
      expect_apply("apply_all", 16'hFFFF, 17, 1);
      for (int k = 0; k < 16; k++) check($sformatf("apply_all_dly%0d", k), 32'(obs_dly[k]), 32'h00);

      // Only written lanes are strobed
      write_dly(5'd3, 8'h2C);
      write_dly(5'd9, 8'h51);
      run_apply(1'b0, 5'd0, 8'h00, -1, 5'd0, 8'h00, -1);
      expect_apply("apply_two", 16'h0208, 17, 1);
      check("apply_two_dly3", 32'(obs_dly[3]), 32'h2C);
      check("apply_two_dly9", 32'(obs_dly[9]), 32'h51);
      run_apply(1'b0, 5'd0, 8'h00, -1, 5'd0, 8'h00, -1);
      expect_apply("apply_clean", 16'h0000, 0, 0);

      // Write in the same cycle as apply is included
      run_apply(1'b1, 5'd7, 8'h3E, -1, 5'd0, 8'h00, -1);
      expect_apply("apply_same", 16'h0080, 17, 1);
      check("apply_same_dly7", 32'(obs_dly[7]), 32'h3E);

      // Out-of-range address and write during busy are both dropped
      write_dly(5'd20, 8'hAA);
      write_dly(5'd2, 8'h11);
      run_apply(1'b0, 5'd0, 8'h00, 5, 5'd5, 8'h77, -1);
      expect_apply("apply_busywr", 16'h0004, 17, 1);
      check("apply_busywr_dly2", 32'(obs_dly[2]), 32'h11);
      run_apply(1'b0, 5'd0, 8'h00, -1, 5'd0, 8'h00, -1);
      expect_apply("apply_after_drop", 16'h0000, 0, 0);

      // Reset in the middle of SET, while lane 12 is being strobed
      write_dly(5'd12, 8'h5C);
      run_apply(1'b0, 5'd0, 8'h00, -1, 5'd0, 8'h00, 12);
      check("midrst_pre_set", 32'(pre_rst_set), 32'h1000);
      check("midrst_pre_dly", 32'(obs_dly[12]), 32'h5C);
      check("midrst_busy_cycles", 32'(busy_cnt), 32'd13);
      check("midrst_ld_count", 32'(ld_cnt), 32'd0);
      check("midrst_strobe_rules", 32'(bad_cnt), 32'h0);

      // Reset restored all shadows to DLY_INIT and marked every lane dirty
      run_apply(1'b0, 5'd0, 8'h00, -1, 5'd0, 8'h00, -1);
      expect_apply("apply_postrst", 16'hFFFF, 17, 1);
      for (int k = 0; k < 16; k++) check($sformatf("apply_postrst_dly%0d", k), 32'(obs_dly[k]), 32'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cmda_bus_ctrl.md
Name: cmda_bus_ctrl

Overview:
Parametrised controller for the whole DDR3 command/address output bus, running in the clk_div domain.
- Pipelines command words to the per-lane single-bit CMD/address output cells (din[1:0] per lane).
- Generates the shared tristate control with an idle float timeout.
- Owns a shadow register per lane for the output delay value.
- Sequences per-lane set strobes followed by one broadcast ld strobe, so delay changes apply atomically.

Parameters:
WIDTH, 16, number of CMD/address lanes (1..32)
DLY_AW, 5, width of the delay lane address; must satisfy 2**DLY_AW >= WIDTH
PIPE_DEPTH, 1, extra command pipeline stages (0..3)
IDLE_CYCLES, 8, consecutive idle clk_div cycles before the bus floats (1..255)
DLY_INIT, 8'h00, reset value of every lane's shadow delay
NOP_PATTERN, all ones (2*WIDTH bits), value driven on dout when no command is valid

Ports:
clk_div  in  1  free-running half-rate clock; the only clock
rst  in  1  asynchronous reset, active high
cmd_in  in  2*WIDTH  command word; lane i occupies bits [2i+1:2i], bit 2i goes out first
cmd_valid  in  1  cmd_in is valid this cycle
dout  out  2*WIDTH  per-lane din to the output cells
tout  out  1  shared tristate control; 1 = float
dly_addr  in  DLY_AW  lane index for a delay write
dly_data  in  8  delay value; 3 LSB are the fine delay
dly_we  in  1  write dly_data into the shadow register of lane dly_addr
dly_apply  in  1  request to push dirty shadow values to the lanes
dly_busy  out  1  apply sequence in progress
lane_dly  out  8  delay value presented to all lanes
lane_set  out  WIDTH  one-hot set strobe (per-lane set_delay)
lane_ld  out  1  broadcast ld strobe (all lanes' ld_delay)

Behaviour:
Interface:
- One clock, clk_div. Reset rst is asynchronous and active-high.
- All state is cleared on rst assertion, independent of clk_div.

Reset values:
- dout = NOP_PATTERN, tout = 1.
- Idle counter = IDLE_CYCLES (saturated).
- dly_busy = 0, lane_set = 0, lane_ld = 0, lane_dly = 0.
- Every shadow register = DLY_INIT; every dirty bit = 1, so the first apply after reset loads all lanes.

Command path:
- cmd_in and cmd_valid pass through PIPE_DEPTH+1 registered stages. Latency is PIPE_DEPTH+1 cycles.
- At the output stage: if valid, dout = the word; otherwise dout = NOP_PATTERN.
- Idle counter: reset to 0 on an output-stage valid; otherwise increments, saturating at IDLE_CYCLES.
- tout = 1 when the counter equals IDLE_CYCLES, else 0.
- tout is registered alongside dout. The first valid word after a float drives tout = 0 in the same cycle as the word appears.

Delay shadow:
- dly_we with dly_addr < WIDTH, while dly_busy = 0: write the shadow register and set that lane's dirty bit.
- Writes with dly_addr >= WIDTH are ignored.
- Writes while dly_busy = 1 are ignored.

Apply FSM, states IDLE, SET, LD:
- IDLE: on dly_apply with any dirty bit set, go to SET with idx = 0 and dly_busy = 1. dly_apply with no dirty bits is ignored; no strobes are issued.
- dly_we and dly_apply in the same IDLE cycle: the write is included in the apply.
- SET: one cycle per lane, for idx = 0..WIDTH-1. If dirty[idx] = 1:
  - lane_set[idx] = 1, lane_dly = shadow[idx], dirty[idx] cleared.
  - Otherwise lane_set = 0.
  - At idx = WIDTH-1, go to LD.
- LD: lane_ld = 1 for exactly one cycle, then return to IDLE with dly_busy = 0.
- Total busy time is WIDTH+1 cycles. lane_set and lane_ld are registered outputs and are never asserted in the same cycle.
- dly_apply while busy is ignored.
- rst mid-sequence: FSM returns to IDLE; strobes drop immediately; shadows = DLY_INIT; all dirty bits = 1.

Command path and delay path are independent; either operates without affecting the other.

Test Plan:
1. Reset with WIDTH=16, PIPE_DEPTH=1, no commands -> dout = all ones, tout = 1, dly_busy = 0; lane_set and lane_ld stay 0 until an apply.
2. cmd_valid pulse with cmd_in = 32'h0000_A5A5 at cycle N -> dout = 32'h0000_A5A5 and tout = 0 at N+2; dout = NOP at N+3; tout returns to 1 at N+2+8.
3. Back-to-back valid commands for 20 cycles -> tout stays 0 throughout; dout tracks cmd_in delayed by 2 cycles with no NOP gaps.
4. After reset, dly_apply -> 16 consecutive lane_set one-hots with lane_dly = 8'h00, then lane_ld for 1 cycle; dly_busy high for 17 cycles.
5. Write lane 3 = 8'h2C and lane 9 = 8'h51, then dly_apply -> only lane_set[3] (data 8'h2C) and lane_set[9] (data 8'h51) pulse, then one lane_ld. A second dly_apply produces no strobes.
6. dly_we to lane 5 during busy, a write to dly_addr = 20, and rst asserted mid-SET -> lane 5 is not dirty after the busy period and the addr-20 write is ignored. On rst, strobes drop asynchronously and the next apply loads all 16 lanes with DLY_INIT.
